// File: rtl/lsu_dcache_port_if.sv
// CPU-side port of the 4-way data cache: word address, byte lanes,
// read/write strobes, delayed read-data return and waitrequest stall.
interface lsu_dcache_port_if #(
  parameter int P_ADDR_W = 25
);
  logic [P_ADDR_W-1:0] o_p_addr;
  logic [3:0]          o_p_byte_en;
  logic [31:0]         o_p_writedata;
  logic                o_p_read;
  logic                o_p_write;
  logic [31:0]         i_p_readdata;
  logic                i_p_readdata_valid;
  logic                i_p_waitrequest;

  modport master (
    output o_p_addr,
    output o_p_byte_en,
    output o_p_writedata,
    output o_p_read,
    output o_p_write,
    input  i_p_readdata,
    input  i_p_readdata_valid,
    input  i_p_waitrequest
  );

  modport slave (
    input  o_p_addr,
    input  o_p_byte_en,
    input  o_p_writedata,
    input  o_p_read,
    input  o_p_write,
    output i_p_readdata,
    output i_p_readdata_valid,
    output i_p_waitrequest
  );
endinterface

// File: rtl/lsu_dcache_port.sv
// Load/store unit between execute and the data cache: one access at a time,
// lane alignment, load extension, registered writeback/done/err pulses.
module lsu_dcache_port #(
  parameter int P_ADDR_W = 25,
  parameter int TIMEOUT  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        busy_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_wdata_o,
  output logic        done_o,
  output logic        err_o,
  lsu_dcache_port_if.master cache
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;
  logic [2:0]        funct3_reg;
  logic              we_reg;
  logic [4:0]        rd_reg;
  logic              wb_we_reg, wb_we_next;
  logic [4:0]        wb_waddr_reg;
  logic [31:0]       wb_wdata_reg;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              latch_req;
  logic              capture;
  logic              req_legal;
  logic              timeout_hit;
  logic              active;
  logic [2:0]        size_bytes;
  logic [3:0]        be_calc;
  logic [31:0]       rd_shifted;
  logic [31:0]       ext_data;

  function automatic logic f_legal(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: f_legal = 1'b1;
      3'b001, 3'b101: f_legal = ~a[0];
      3'b010:         f_legal = (a == 2'b00);
      default:        f_legal = 1'b0;
    endcase
  endfunction

  assign req_legal   = f_legal(req_funct3_i, req_addr_i[1:0]);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == TO_LAST);
  assign busy_o      = (state_reg != IDLE) | (req_valid_i & req_legal);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    wb_we_next = 1'b0;
    latch_req  = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (req_valid_i) begin
          if (req_legal) begin
            latch_req  = 1'b1;
            state_next = REQ;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      REQ: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (!cache.i_p_waitrequest) begin
          if (we_reg) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (cache.i_p_readdata_valid) begin
            capture    = 1'b1;
            state_next = IDLE;
            done_next  = 1'b1;
            wb_we_next = (rd_reg != 5'd0);
          end else begin
            state_next = WAIT;
          end
        end
        // A completing access wins over an expiring timeout on the same edge.
        if (state_next != IDLE && timeout_hit) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cache.i_p_readdata_valid) begin
          capture    = 1'b1;
          state_next = IDLE;
          done_next  = 1'b1;
          wb_we_next = (rd_reg != 5'd0);
        end else if (timeout_hit) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      funct3_reg   <= '0;
      we_reg       <= 1'b0;
      rd_reg       <= '0;
      wb_we_reg    <= 1'b0;
      wb_waddr_reg <= '0;
      wb_wdata_reg <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wb_we_reg <= wb_we_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      if (latch_req) begin
        addr_reg   <= req_addr_i;
        wdata_reg  <= req_wdata_i;
        funct3_reg <= req_funct3_i;
        we_reg     <= req_we_i;
        rd_reg     <= req_rd_i;
      end
      if (capture) begin
        wb_waddr_reg <= rd_reg;
        wb_wdata_reg <= ext_data;
      end
    end
  end

  // Lane n is enabled when it falls inside [offset, offset + size).
  always_comb begin
    case (funct3_reg)
      3'b000, 3'b100: size_bytes = 3'd1;
      3'b001, 3'b101: size_bytes = 3'd2;
      default:        size_bytes = 3'd4;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign be_calc[gi] = (3'(gi) >= {1'b0, addr_reg[1:0]}) &&
                           (3'(gi) < ({1'b0, addr_reg[1:0]} + size_bytes));
    end
  endgenerate

  assign rd_shifted = cache.i_p_readdata >> {addr_reg[1:0], 3'b000};

  always_comb begin
    case (funct3_reg)
      3'b000:  ext_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  ext_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  ext_data = {24'd0, rd_shifted[7:0]};
      3'b101:  ext_data = {16'd0, rd_shifted[15:0]};
      default: ext_data = rd_shifted;
    endcase
  end

  // Cache-side outputs come straight from latched state, so they hold under stall.
  assign active              = (state_reg == REQ);
  assign cache.o_p_read      = active & ~we_reg;
  assign cache.o_p_write     = active & we_reg;
  assign cache.o_p_addr      = active ? addr_reg[P_ADDR_W+1:2] : '0;
  assign cache.o_p_byte_en   = active ? be_calc : 4'd0;
  assign cache.o_p_writedata = active ? (wdata_reg << {addr_reg[1:0], 3'b000}) : 32'd0;

  assign wb_we_o    = wb_we_reg;
  assign wb_waddr_o = wb_waddr_reg;
  assign wb_wdata_o = wb_wdata_reg;
  assign done_o     = done_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_lsu_dcache_port.sv
// Bench for lsu_dcache_port: directed cases then random accesses against
// a transaction-level model; a second instance with a short timeout.
module tb_lsu_dcache_port;
  localparam int AW = 25;

  logic        clk;
  logic        rst;
  logic        req_valid, req_valid2, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        busy, wb_we, done, err;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        busy2, wb_we2, done2, err2;
  logic [4:0]  wb_waddr2;
  logic [31:0] wb_wdata2;
  int          checks = 0;
  int          failures = 0;

  lsu_dcache_port_if #(.P_ADDR_W(AW)) cif ();
  lsu_dcache_port_if #(.P_ADDR_W(AW)) cif2 ();

  lsu_dcache_port #(.P_ADDR_W(AW), .TIMEOUT(256)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_rd_i(req_rd), .busy_o(busy), .wb_we_o(wb_we), .wb_waddr_o(wb_waddr),
    .wb_wdata_o(wb_wdata), .done_o(done), .err_o(err), .cache(cif)
  );

  lsu_dcache_port #(.P_ADDR_W(AW), .TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst), .req_valid_i(req_valid2), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_rd_i(req_rd), .busy_o(busy2), .wb_we_o(wb_we2), .wb_waddr_o(wb_waddr2),
    .wb_wdata_o(wb_wdata2), .done_o(done2), .err_o(err2), .cache(cif2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (a % 2) == 0;
      3'd2:       return (a % 4) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic int m_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int v;
    v = ((1 << m_size(f3)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdata);
    logic [31:0] v;
    int b;
    v = rdata >> (8 * (a % 4));
    case (f3)
      3'd0: begin b = int'(v & 32'hFF);   return (b >= 128)   ? 32'(b - 256)   : 32'(b); end
      3'd1: begin b = int'(v & 32'hFFFF); return (b >= 32768) ? 32'(b - 65536) : 32'(b); end
      3'd4: return v & 32'hFF;
      3'd5: return v & 32'hFFFF;
      default: return v;
    endcase
  endfunction

  // One complete access: request, nwait stall cycles, data ndelay cycles after accept.
  task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input int nwait,
                        input int ndelay, input logic [31:0] rdata);
    bit legal;
    logic [31:0] exp_addr;
    legal    = m_legal(f3, a);
    exp_addr = (a >> 2) & ((32'd1 << AW) - 1);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    #1 chk("busy_req", busy, legal);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    if (!legal) begin
      #1;
      chk("ill_err", err, 1);
      chk("ill_nocache", {cif.o_p_read, cif.o_p_write}, 0);
      chk("ill_busy", busy, 0);
      chk("ill_done", done, 0);
      @(negedge clk);
      #1 chk("ill_err_fall", err, 0);
      return;
    end
    for (int i = 0; i <= nwait; i++) begin
      cif.i_p_waitrequest    = (i < nwait);
      cif.i_p_readdata_valid = we ? 1'($urandom) : (i == nwait && ndelay == 0);
      cif.i_p_readdata       = (!we && i == nwait && ndelay == 0) ? rdata : $urandom;
      #1;
      chk("req_rw", {cif.o_p_read, cif.o_p_write}, {~we, we});
      chk("req_addr", cif.o_p_addr, exp_addr);
      chk("req_be", cif.o_p_byte_en, m_be(f3, a));
      if (we) chk("req_wdata", cif.o_p_writedata, wd << (8 * (a % 4)));
      chk("req_busy", busy, 1);
      @(negedge clk);
    end
    cif.i_p_waitrequest    = 1'b0;
    cif.i_p_readdata_valid = 1'b0;
    if (!we && ndelay > 0) begin
      for (int j = 1; j < ndelay; j++) begin
        cif.i_p_readdata = $urandom;
        #1;
        chk("wait_noread", cif.o_p_read, 0);
        chk("wait_busy", busy, 1);
        chk("wait_done", done, 0);
        @(negedge clk);
      end
      cif.i_p_readdata_valid = 1'b1;
      cif.i_p_readdata       = rdata;
      @(negedge clk);
      cif.i_p_readdata_valid = 1'b0;
    end
    #1;
    chk("done", done, 1);
    chk("done_err", err, 0);
    chk("done_busy", busy, 0);
    if (we) chk("st_wb", wb_we, 0);
    else begin
      chk("ld_wb_we", wb_we, rd != 5'd0);
      chk("ld_waddr", wb_waddr, rd);
      chk("ld_wdata", wb_wdata, m_load(f3, a, rdata));
    end
    @(negedge clk);
    #1 chk("pulse_fall", {done, wb_we, err}, 0);
  endtask

  initial begin
    logic [2:0] f3_tab [12];
    logic [2:0] f3;
    logic [31:0] a;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
    rst = 1'b1; req_valid = 0; req_valid2 = 0; req_we = 0; req_funct3 = 0;
    req_addr = 0; req_wdata = 0; req_rd = 0;
    cif.i_p_readdata = 0; cif.i_p_readdata_valid = 0; cif.i_p_waitrequest = 0;
    cif2.i_p_readdata = 0; cif2.i_p_readdata_valid = 0; cif2.i_p_waitrequest = 0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_pulses", {busy, wb_we, done, err}, 0);
    chk("rst_wb", {wb_waddr, wb_wdata[26:0]}, 0);
    chk("rst_rw", {cif.o_p_read, cif.o_p_write, cif.o_p_byte_en}, 0);
    chk("rst_addr", cif.o_p_addr, 0);
    chk("rst_wd", cif.o_p_writedata, 0);
    rst = 1'b0;

    access(1, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0, 0, 0, 0);
    access(1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 5'd0, 0, 0, 0);
    access(0, 3'd0, 32'h0000_0102, 0, 5'd5, 0, 3, 32'h0080_0000);
    access(0, 3'd5, 32'h0000_0102, 0, 5'd6, 0, 3, 32'h0080_0000);
    access(0, 3'd2, 32'h0000_0200, 0, 5'd9, 4, 0, 32'h1234_5678);
    access(0, 3'd2, 32'h0000_0101, 0, 5'd3, 0, 0, 0);
    access(0, 3'd2, 32'h0000_0300, 0, 5'd0, 0, 1, 32'hCAFE_F00D);
    access(0, 3'd1, 32'h0000_0012, 0, 5'd31, 1, 2, 32'h8001_7FFF);
    access(1, 3'd1, 32'h0000_0006, 32'h0000_BEEF, 5'd0, 2, 0, 0);
    access(0, 3'd7, 32'h0000_0000, 0, 5'd1, 0, 0, 0);

    // Short-timeout instance: stall 4 cycles, then never return data.
    @(negedge clk);
    req_valid2 = 1'b1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h300; req_rd = 5'd4;
    #1 chk("to_busy_req", busy2, 1);
    @(negedge clk);
    req_valid2 = 1'b0;
    cif2.i_p_waitrequest = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) cif2.i_p_waitrequest = 1'b0;
      #1;
      chk("to_pending", {err2, done2}, 0);
      chk("to_busy", busy2, 1);
      @(negedge clk);
    end
    #1;
    chk("to_err", err2, 1);
    chk("to_nodone", {done2, wb_we2}, 0);
    chk("to_idle", {busy2, cif2.o_p_read}, 0);
    @(negedge clk);
    #1 chk("to_err_fall", err2, 0);

    // Reset while waiting for load data: late data must not write back.
    @(negedge clk);
    req_valid = 1'b1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h400; req_rd = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_wait_idle", {busy, cif.o_p_read, done, err, wb_we}, 0);
    cif.i_p_readdata_valid = 1'b1; cif.i_p_readdata = 32'h5555_AAAA;
    @(negedge clk);
    cif.i_p_readdata_valid = 1'b0;
    #1 chk("rst_wait_nowb", {wb_we, done, busy}, 0);

    for (int n = 0; n < 60; n++) begin
      f3 = f3_tab[$urandom_range(0, 11)];
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~((m_size(f3) == 1) ? 32'd0 : 32'(m_size(f3) - 1));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(negedge clk);
        cif.i_p_readdata_valid = 1'($urandom);
        cif.i_p_readdata       = $urandom;
        #1 chk("idle_quiet", {busy, done, wb_we, err}, 0);
      end
      cif.i_p_readdata_valid = 1'b0;
      access(1'($urandom), f3, a, $urandom, 5'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 4), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
